// File: rtl/mmio_spi_master.sv
// mmio_spi_master: MMIO-mapped SPI mode-0 master with TX/RX byte FIFOs.
// Data register (addr 0): write pushes {ignore, byte} into TX, read pops RX head.
// Status register (addr 1): flags only, no side effects.
// Optional macro SPI_LOOPBACK_EN: receive path samples internal mosi instead of spi_miso.
module mmio_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TAIL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW:0]   r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [8:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];

  logic [DW-1:0] r_div;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_ign;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_cs_n;

  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [8:0]    w_tx_head;
  logic          w_div_end, w_rise, w_fall, w_byte_done;
  logic          w_rx_in;

`ifdef SPI_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = spi_miso;
  assign w_rx_in       = r_mosi;
`else
  assign w_rx_in = spi_miso;
`endif

  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];

  // Fullness/emptiness come from registered pointers, so same-cycle pops never rescue a push.
  assign w_tx_push = spi_wr && !spi_addr && !w_tx_full;
  assign w_rx_pop  = spi_rd && !spi_addr && !w_rx_empty;
  assign w_rx_push = w_byte_done && !r_ign && !w_rx_full;

  assign spi_dout         = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[AW-1:0]];
  assign spi_buffer_full  = w_tx_full;
  assign spi_buffer_empty = w_tx_empty && (r_state == S_IDLE);
  assign spi_data_avail   = !w_rx_empty;
  assign spi_sclk         = r_sclk;
  assign spi_mosi         = r_mosi;
  assign spi_cs_n         = r_cs_n;

  // FIFO storage writes (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= {spi_ignore_response, spi_din};
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_shift;
  end

  // FIFO pointer updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
    end
  end

  // Engine state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Engine next-state and per-cycle event decode
  always_comb begin
    w_state_next = r_state;
    w_div_end    = (r_div == DIV_LAST);
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_byte_done  = 1'b0;
    w_tx_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_tx_empty) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_tx_pop     = 1'b1;
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_div_end) begin
          if (!r_sclk) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            if (r_bitcnt == 3'd7) begin
              w_byte_done  = 1'b1;
              w_state_next = w_tx_empty ? S_TAIL : S_LOAD;
            end
          end
        end
      end
      S_TAIL: begin
        if (w_div_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Engine datapath: divider, bit counter, shift register and SPI pins.
  // cs_n and mosi=bit7 are registered on entry to LOAD so both are valid
  // throughout the LOAD cycle; the shift register is filled as LOAD ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ign    <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_cs_n   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_LOAD) begin
            r_cs_n <= 1'b0;
            r_mosi <= w_tx_head[7];
          end
        end
        S_LOAD: begin
          r_shift  <= w_tx_head[7:0];
          r_ign    <= w_tx_head[8];
          r_div    <= '0;
          r_bitcnt <= '0;
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (w_rise) begin
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[6:0], w_rx_in};
            end
            if (w_fall) begin
              r_sclk <= 1'b0;
              if (w_byte_done) begin
                r_mosi <= (w_state_next == S_LOAD) ? w_tx_head[7] : 1'b0;
              end else begin
                r_mosi   <= r_shift[7];
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_TAIL: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_cs_n <= 1'b1;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_spi_master.sv
// Testbench for mmio_spi_master (CLK_DIV=2, FIFO_DEPTH=4).
// miso can be looped from mosi externally, so echo tests hold with or
// without SPI_LOOPBACK_EN defined.
module tb_mmio_spi_master;
  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst, spi_wr, spi_rd, spi_addr, spi_ign;
  logic [7:0] spi_din, spi_dout;
  logic       full, empty, avail, sclk, mosi, miso, cs_n;
  logic       lb;
  logic       ext_miso;
  logic [7:0] miso_pat;
  int         miso_base;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  int         sclk_rises = 0;
  int         sclk_falls = 0;
  int         cs_rises   = 0;
  logic [7:0] mosi_bits  = 8'h00;
  time        last_rise  = 0;
  time        period     = 0;

  always #5 clk = ~clk;

  assign ext_miso = miso_pat[3'(7 - (sclk_falls - miso_base))];
  assign miso     = lb ? mosi : ext_miso;

  mmio_spi_master #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spi_wr              (spi_wr),
    .spi_rd              (spi_rd),
    .spi_addr            (spi_addr),
    .spi_din             (spi_din),
    .spi_ignore_response (spi_ign),
    .spi_dout            (spi_dout),
    .spi_buffer_full     (full),
    .spi_buffer_empty    (empty),
    .spi_data_avail      (avail),
    .spi_sclk            (sclk),
    .spi_mosi            (mosi),
    .spi_miso            (miso),
    .spi_cs_n            (cs_n)
  );

  always @(posedge sclk) begin
    sclk_rises <= sclk_rises + 1;
    mosi_bits  <= {mosi_bits[6:0], mosi};
    period     <= $time - last_rise;
    last_rise  <= $time;
  end

  always @(negedge sclk) sclk_falls <= sclk_falls + 1;
  always @(posedge cs_n) cs_rises <= cs_rises + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic addr, input logic [7:0] d, input logic ign);
    spi_wr   = 1'b1;
    spi_addr = addr;
    spi_din  = d;
    spi_ign  = ign;
    @(negedge clk);
    spi_wr   = 1'b0;
    spi_addr = 1'b0;
  endtask

  task automatic rd_check();
    logic [7:0] e;
    spi_rd   = 1'b1;
    spi_addr = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      chk("rd_empty", {24'h0, spi_dout}, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk("rd_data", {24'h0, spi_dout}, {24'h0, e});
    end
    @(negedge clk);
    spi_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (empty) break;
    end
    chk(tag, {31'h0, empty}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_cs;
    bit reached;
    rst = 1'b1; spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = 1'b0;
    spi_din = 8'h00; spi_ign = 1'b0; lb = 1'b1; miso_pat = 8'h00; miso_base = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",  {31'h0, cs_n},  32'h1);
    chk("rst_sclk",  {31'h0, sclk},  32'h0);
    chk("rst_mosi",  {31'h0, mosi},  32'h0);
    chk("rst_dout",  {24'h0, spi_dout}, 32'h0);
    chk("rst_full",  {31'h0, full},  32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_avail", {31'h0, avail}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single echoed byte: latency, pulse count, period, bit order
    base_r = sclk_rises;
    exp_q.push_back(8'hA5);
    wr(1'b0, 8'hA5, 1'b0);
    chk("a5_empty_fell", {31'h0, empty}, 32'h0);
    chk("a5_cs_still_hi", {31'h0, cs_n}, 32'h1);
    @(negedge clk);
    chk("a5_cs_low", {31'h0, cs_n}, 32'h0);
    wait_idle("a5_idle");
    chk("a5_pulses", sclk_rises - base_r, 8);
    chk("a5_mosi", {24'h0, mosi_bits}, 32'hA5);
    chk("a5_period", 32'(period), 32'(4 * CLK_DIV * 5));
    chk("a5_avail", {31'h0, avail}, 32'h1);
    rd_check();
    chk("a5_avail_clr", {31'h0, avail}, 32'h0);

    // Ignored response: full transfer, nothing captured
    base_r = sclk_rises;
    wr(1'b0, 8'h3C, 1'b1);
    wait_idle("3c_idle");
    chk("3c_pulses", sclk_rises - base_r, 8);
    chk("3c_mosi", {24'h0, mosi_bits}, 32'h3C);
    chk("3c_avail", {31'h0, avail}, 32'h0);
    chk("3c_cs_hi", {31'h0, cs_n}, 32'h1);

    // Status-register write has no effect
    wr(1'b1, 8'hEE, 1'b0);
    chk("stwr_empty", {31'h0, empty}, 32'h1);
    @(negedge clk);
    chk("stwr_cs", {31'h0, cs_n}, 32'h1);

    // Burst of five, sixth dropped while full; RX keeps first four
    base_r  = sclk_rises;
    base_cs = cs_rises;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      wr(1'b0, 8'(i), 1'b0);
    end
    spi_rd = 1'b1; spi_addr = 1'b1;
    #1;
    chk("burst_full", {31'h0, full}, 32'h1);
    @(negedge clk);
    spi_rd = 1'b0; spi_addr = 1'b0;
    wr(1'b0, 8'h06, 1'b0);
    chk("burst_cs_mid", cs_rises - base_cs, 0);
    wait_idle("burst_idle");
    chk("burst_pulses", sclk_rises - base_r, 40);
    chk("burst_cs_rises", cs_rises - base_cs, 1);
    chk("burst_avail", {31'h0, avail}, 32'h1);
    for (int i = 0; i < DEPTH; i++) rd_check();
    chk("burst_avail_clr", {31'h0, avail}, 32'h0);
    rd_check();

    // External miso pattern, changing on sclk falls
    lb = 1'b0;
    miso_pat  = 8'h5A;
    miso_base = sclk_falls;
    exp_q.push_back(8'h5A);
    wr(1'b0, 8'hFF, 1'b0);
    wait_idle("miso_idle");
    rd_check();
    lb = 1'b1;

    // Reset mid-byte after three sclk pulses
    base_r  = sclk_rises;
    reached = 1'b0;
    wr(1'b0, 8'h77, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if (sclk_rises - base_r >= 3) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reached", {31'h0, reached}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cs",    {31'h0, cs_n},  32'h1);
    chk("mid_sclk",  {31'h0, sclk},  32'h0);
    chk("mid_mosi",  {31'h0, mosi},  32'h0);
    chk("mid_empty", {31'h0, empty}, 32'h1);
    chk("mid_avail", {31'h0, avail}, 32'h0);
    @(negedge clk);
    base_r = sclk_rises;
    exp_q.push_back(8'hC3);
    wr(1'b0, 8'hC3, 1'b0);
    wait_idle("post_idle");
    chk("post_pulses", sclk_rises - base_r, 8);
    chk("post_mosi", {24'h0, mosi_bits}, 32'hC3);
    rd_check();
    chk("post_avail", {31'h0, avail}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
